// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises the line, validates the start bit, samples each bit at
// mid-bit, checks the stop bit and hands bytes to the consumer on a valid/ready handshake.
module uart_rx_deframer #(
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BAUD_COUNT = CLK_FREQ / BAUD_RATE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  rx_busy
);

    localparam int unsigned Half = BAUD_COUNT / 2;
    localparam int unsigned CntW = (BAUD_COUNT > 2) ? $clog2(BAUD_COUNT) : 1;
    localparam int unsigned BitW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CntW-1:0] HalfCnt = CntW'(Half - 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(BAUD_COUNT - 1);
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreakWait
    } state_e;

    state_e                  state_q, state_d;
    logic                    sync_q;
    logic                    rxs_q;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [BitW-1:0]         bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    good_q, good_d;
    logic                    frame_err_q, frame_err_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    overrun_q, overrun_d;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b1;
            rxs_q  <= 1'b1;
        end else begin
            sync_q <= serial_in;
            rxs_q  <= sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            good_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            good_q      <= good_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        good_d      = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rxs_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HalfCnt) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end else begin
                        // Line returned high before mid start bit: treat as a glitch.
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[DATA_WIDTH-1:1]};
                    if (bit_idx_q == LastBit) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            StStop: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        good_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreakWait;
                    end
                end
            end
            StBreakWait: begin
                if (rxs_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Commit runs one cycle after the stop sample; shift_q is stable then because
    // only StData modifies it.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (good_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: serialises frames onto the line and compares the
// outputs against a byte-level model of the handshake, error and overrun rules.
module tb_uart_rx_deframer;

    localparam int N    = 16;
    localparam int HALF = N / 2;
    localparam int DW   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          serial_in = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun;
    logic          rx_busy;

    uart_rx_deframer #(
        .BAUD_RATE (100000),
        .CLK_FREQ  (1600000),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .serial_in(serial_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive observers of DUT pulses and handshakes.
    int            ferr_seen = 0;
    int            ovr_seen = 0;
    int            busy_cnt = 0;
    int            rise_cyc = -1;
    logic          prev_valid = 1'b0;
    logic [DW-1:0] acc_q[$];

    always @(negedge clk) begin
        if (frame_err) ferr_seen <= ferr_seen + 1;
        if (overrun) ovr_seen <= ovr_seen + 1;
        if (rx_busy) busy_cnt <= busy_cnt + 1;
        if (rx_valid && !prev_valid) rise_cyc <= cyc;
        prev_valid <= rx_valid;
        if (rst_n && rx_valid && rx_ready) acc_q.push_back(rx_data);
    end

    // Byte-level reference model.
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data = '0;
    int            m_ferr = 0;
    int            m_ovr = 0;
    logic [DW-1:0] m_acc[$];

    task automatic model_frame(input logic [DW-1:0] d, input logic stop, input logic rdy);
        if (!stop) begin
            m_ferr++;
        end else if (!m_valid || rdy) begin
            if (m_valid) m_acc.push_back(m_data);
            m_data  = d;
            m_valid = 1'b1;
        end else begin
            m_ovr++;
        end
    endtask

    task automatic model_accept();
        if (m_valid) begin
            m_acc.push_back(m_data);
            m_valid = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag);
        check({tag, "_valid"}, 32'(rx_valid), 32'(m_valid));
        check({tag, "_data"}, 32'(rx_data), 32'(m_data));
        check({tag, "_ferr"}, ferr_seen, m_ferr);
        check({tag, "_ovr"}, ovr_seen, m_ovr);
    endtask

    task automatic drive(input logic v, input int n);
        serial_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        model_accept();
    endtask

    // One full frame, 10 bit periods. ready_k >= 0 pulses rx_ready in that cycle only;
    // rst_k >= 0 holds rst_n low for 3 cycles starting there.
    task automatic send_frame(input logic [DW-1:0] d, input logic stop, input int ready_k,
                              input int rst_k);
        int b;
        for (int k = 0; k < (DW + 2) * N; k++) begin
            b = k / N;
            if (b == 0) serial_in = 1'b0;
            else if (b <= DW) serial_in = d[b-1];
            else serial_in = stop;
            if (k == 0) start_cyc = cyc;
            if (ready_k >= 0) rx_ready = (k == ready_k);
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                check("rst_valid", 32'(rx_valid), 0);
                check("rst_data", 32'(rx_data), 0);
                check("rst_busy", 32'(rx_busy), 0);
                check("rst_ferr", 32'(frame_err), 0);
                check("rst_ovr", 32'(overrun), 0);
                m_valid = 1'b0;
                m_data  = '0;
            end
            if (k == rst_k + 3) rst_n = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    logic [DW-1:0] loop_bytes[4] = '{8'h00, 8'hFF, 8'h5A, 8'hC3};

    initial begin
        int            b0;
        logic [DW-1:0] d;
        logic          stop;

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(rx_valid), 0);
        check("reset_data", 32'(rx_data), 0);
        check("reset_ferr", 32'(frame_err), 0);
        check("reset_ovr", 32'(overrun), 0);
        check("reset_busy", 32'(rx_busy), 0);
        rst_n = 1'b1;
        drive(1'b1, 5);

        // Single frame, consumer not ready; valid held until a ready pulse.
        send_frame(8'hA5, 1'b1, -1, -1);
        model_frame(8'hA5, 1'b1, 1'b0);
        check_out("t1");
        check("t1_latency", rise_cyc - start_cyc, 2 + 1 + HALF + (DW + 1) * N + 1);
        drive(1'b1, $urandom_range(5, 30));
        check("t1_hold", 32'(rx_valid), 32'(m_valid));
        accept();
        check_out("t1_acc");

        // Short low glitch is rejected, then a real frame follows.
        b0 = busy_cnt;
        drive(1'b0, 4);
        drive(1'b1, 20);
        check("t2_busy_seen", 32'(busy_cnt > b0), 1);
        check("t2_busy_idle", 32'(rx_busy), 0);
        check_out("t2_glitch");
        send_frame(8'h3C, 1'b1, -1, -1);
        model_frame(8'h3C, 1'b1, 1'b0);
        check_out("t2_frame");
        accept();

        // Bad stop bit followed by a held-low line.
        send_frame(8'h3C, 1'b0, -1, -1);
        drive(1'b0, 40);
        model_frame(8'h3C, 1'b0, 1'b0);
        check_out("t3_err");
        check("t3_busy_low", 32'(rx_busy), 1);
        drive(1'b1, 5);
        check("t3_busy_high", 32'(rx_busy), 0);
        send_frame(8'h55, 1'b1, -1, -1);
        model_frame(8'h55, 1'b1, 1'b0);
        check_out("t3_next");
        accept();

        // Back-to-back frames: overrun, then same-cycle accept+commit.
        send_frame(8'h11, 1'b1, -1, -1);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, -1, -1);
        model_frame(8'h22, 1'b1, 1'b0);
        check_out("t4_ovr");
        accept();
        check_out("t4_ovr_acc");
        send_frame(8'h11, 1'b1, -1, -1);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 2 + 1 + HALF + (DW + 1) * N, -1);
        model_frame(8'h22, 1'b1, 1'b1);
        check_out("t4_swap");

        // Reset during bit 4 of 0xF0, then a clean frame.
        send_frame(8'hF0, 1'b1, -1, (DW - 3) * N + HALF);
        check_out("t5_after");
        check("t5_busy", 32'(rx_busy), 0);
        drive(1'b1, 5);
        send_frame(8'h81, 1'b1, -1, -1);
        model_frame(8'h81, 1'b1, 1'b0);
        check_out("t5_next");
        accept();

        // Streaming consumer: fixed loopback bytes then random frames, some with bad stop.
        rx_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i < 4) begin
                d    = loop_bytes[i];
                stop = 1'b1;
            end else begin
                d    = DW'($urandom);
                stop = ($urandom_range(0, 3) != 0);
            end
            send_frame(d, stop, -1, -1);
            model_frame(d, stop, 1'b1);
            model_accept();
            drive(1'b1, stop ? $urandom_range(0, 3) : $urandom_range(3, 12));
        end
        rx_ready = 1'b0;
        drive(1'b1, 5);
        check_out("t6_stream");

        check("acc_count", acc_q.size(), m_acc.size());
        for (int i = 0; i < m_acc.size(); i++) begin
            if (i < acc_q.size()) check($sformatf("acc_%0d", i), 32'(acc_q[i]), 32'(m_acc[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
